// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StFill    = 2'b00,
    StRun     = 2'b01,
    StBrStall = 2'b10,
    StFreeze  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdEx  = 2'b01,
    FwdMem = 2'b10,
    FwdWb  = 2'b11
  } fwd_e;

  localparam logic [4:0] RegZero = 5'd0;

  // A source register depends on a producer only if it is actually read and is not r0.
  function automatic logic reg_match(logic [4:0] dest, logic [4:0] src, logic used);
    return used && (dest == src) && (dest != RegZero);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux select for one ID-stage operand (EX > MEM > WB > RF).
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  logic [4:0] ex_dest,
  input  logic       ex_rf_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_rf_en,
  input  logic [4:0] wb_dest,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FwdRf;
    if (ex_rf_en && reg_match(ex_dest, src, used)) begin
      sel = FwdEx;
    end else if (mem_rf_en && reg_match(mem_dest, src, used)) begin
      sel = FwdMem;
    end else if (wb_rf_en && reg_match(wb_dest, src, used)) begin
      sel = FwdWb;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Front-end sequencing for the 5-stage pipeline: fill after reset, load-use and
// branch-on-load bubbles, external freeze, and ID operand forwarding selects.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             hold,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic [4:0]       ex_dest,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [4:0]       mem_dest,
  input  logic             mem_rf_en,
  input  logic [4:0]       wb_dest,
  input  logic             wb_rf_en,
  output logic             pc_le,
  output logic             npc_le,
  output logic             if_id_le,
  output logic             cmux,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_o
);

  localparam logic [2:0] FillLast = 3'(FILL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       fill_q, fill_d;
  logic [CNT_W-1:0] stall_q;
  logic             bubble;
  logic             ex_rs_hit, ex_rt_hit;
  logic             lu, brl;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign ex_rs_hit = reg_match(ex_dest, id_rs, id_uses_rs);
  assign ex_rt_hit = reg_match(ex_dest, id_rt, id_uses_rt);
  assign lu        = ex_load && ex_rf_en && (ex_rs_hit || ex_rt_hit);
  // Branch operands are consumed in ID, so a load feeding rs needs a second bubble.
  assign brl       = lu && id_branch && ex_rs_hit;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    bubble  = 1'b1;
    unique case (state_q)
      StFill: begin
        fill_d = fill_q + 3'd1;
        if (fill_q == FillLast) begin
          state_d = StRun;
        end
      end
      // Leaving FREEZE goes through the same hazard checks as RUN so no hazard is lost.
      StRun, StFreeze: begin
        if (hold) begin
          state_d = StFreeze;
        end else if (brl) begin
          state_d = StBrStall;
        end else begin
          state_d = StRun;
          bubble  = lu;
        end
      end
      StBrStall: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StFill;
      fill_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
    end else if (bubble && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  fwd_select u_fwd_a (
    .src       (id_rs),
    .used      (id_uses_rs),
    .ex_dest   (ex_dest),
    .ex_rf_en  (ex_rf_en),
    .mem_dest  (mem_dest),
    .mem_rf_en (mem_rf_en),
    .wb_dest   (wb_dest),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .src       (id_rt),
    .used      (id_uses_rt),
    .ex_dest   (ex_dest),
    .ex_rf_en  (ex_rf_en),
    .mem_dest  (mem_dest),
    .mem_rf_en (mem_rf_en),
    .wb_dest   (wb_dest),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_b_raw)
  );

  assign pc_le     = ~bubble;
  assign npc_le    = ~bubble;
  assign if_id_le  = ~bubble;
  assign cmux      = bubble;
  assign fwd_a     = {2{Reset}} & fwd_a_raw;
  assign fwd_b     = {2{Reset}} & fwd_b_raw;
  assign stall_cnt = stall_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench: two controller instances (default and small-counter/short-fill) checked against
// a rule-level reference model, plus a vector table and hand-written corner sequences.
module tb_hazard_stall_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       hold;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic       id_uses_rs, id_uses_rt, id_branch;
  logic       ex_rf_en, ex_load, mem_rf_en, wb_rf_en;

  logic [1:0]  pc_le, npc_le, if_id_le, cmux;
  logic [1:0]  fa_o [2];
  logic [1:0]  fb_o [2];
  logic [1:0]  st_o [2];
  logic [15:0] sc0;
  logic [2:0]  sc1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  hazard_stall_controller #(.FILL_CYCLES(3), .CNT_W(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .hold(hold), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .ex_dest(ex_dest), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_dest(mem_dest), .mem_rf_en(mem_rf_en), .wb_dest(wb_dest), .wb_rf_en(wb_rf_en),
    .pc_le(pc_le[0]), .npc_le(npc_le[0]), .if_id_le(if_id_le[0]), .cmux(cmux[0]),
    .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cnt(sc0), .state_o(st_o[0])
  );

  hazard_stall_controller #(.FILL_CYCLES(1), .CNT_W(3)) dut1 (
    .Clk(Clk), .Reset(Reset), .hold(hold), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .ex_dest(ex_dest), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_dest(mem_dest), .mem_rf_en(mem_rf_en), .wb_dest(wb_dest), .wb_rf_en(wb_rf_en),
    .pc_le(pc_le[1]), .npc_le(npc_le[1]), .if_id_le(if_id_le[1]), .cmux(cmux[1]),
    .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cnt(sc1), .state_o(st_o[1])
  );

  // ---------------- reference model ----------------
  int unsigned m_state [2];
  int unsigned m_fill  [2];
  int unsigned m_stall [2];
  int unsigned m_next  [2];
  bit          m_bub   [2];

  function automatic int unsigned fill_len(int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int unsigned cnt_max(int i);
    return (i == 0) ? 65535 : 7;
  endfunction

  function automatic bit mt(logic [4:0] d, logic [4:0] r, logic u);
    return u && (d == r) && (d != 5'd0);
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] r, logic u);
    logic [4:0] d [3];
    logic       e [3];
    d[0] = ex_dest;  e[0] = ex_rf_en;
    d[1] = mem_dest; e[1] = mem_rf_en;
    d[2] = wb_dest;  e[2] = wb_rf_en;
    if (!Reset) return 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (e[k] && mt(d[k], r, u)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_fill[i]  = 0;
      m_stall[i] = 0;
    end
  endtask

  task automatic model_eval(input int i);
    bit rsx, lu, brl;
    rsx = mt(ex_dest, id_rs, id_uses_rs);
    lu  = ex_load && ex_rf_en && (rsx || mt(ex_dest, id_rt, id_uses_rt));
    brl = lu && id_branch && rsx;
    if (!Reset) begin
      m_bub[i] = 1; m_next[i] = 0;
    end else if (m_state[i] == 0) begin
      m_bub[i]  = 1;
      m_next[i] = (m_fill[i] + 1 >= fill_len(i)) ? 1 : 0;
    end else if (m_state[i] == 2) begin
      m_bub[i] = 1; m_next[i] = 1;
    end else if (hold) begin
      m_bub[i] = 1; m_next[i] = 3;
    end else if (brl) begin
      m_bub[i] = 1; m_next[i] = 2;
    end else begin
      m_bub[i] = lu; m_next[i] = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sc_of(int i);
    return (i == 0) ? {16'd0, sc0} : {29'd0, sc1};
  endfunction

  // Called at a falling edge: compare both DUTs with the model, then advance on the rising edge.
  task automatic sample_and_advance(input string tag);
    for (int i = 0; i < 2; i++) begin
      model_eval(i);
      chk($sformatf("%s_le%0d", tag, i), {29'd0, pc_le[i], npc_le[i], if_id_le[i]},
          m_bub[i] ? 32'd0 : 32'd7);
      chk($sformatf("%s_cmux%0d", tag, i), {31'd0, cmux[i]}, {31'd0, m_bub[i]});
      chk($sformatf("%s_fa%0d", tag, i), {30'd0, fa_o[i]}, {30'd0, ref_fwd(id_rs, id_uses_rs)});
      chk($sformatf("%s_fb%0d", tag, i), {30'd0, fb_o[i]}, {30'd0, ref_fwd(id_rt, id_uses_rt)});
      chk($sformatf("%s_st%0d", tag, i), {30'd0, st_o[i]}, m_state[i]);
      chk($sformatf("%s_sc%0d", tag, i), sc_of(i), m_stall[i]);
    end
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        if (m_state[i] == 0) m_fill[i]++;
        if (m_bub[i] && m_stall[i] < cnt_max(i)) m_stall[i]++;
        m_state[i] = m_next[i];
      end
    end
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge Clk);
    sample_and_advance(tag);
  endtask

  task automatic clear_inputs();
    hold = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_branch = 0;
    ex_dest = 0; ex_rf_en = 0; ex_load = 0; mem_dest = 0; mem_rf_en = 0;
    wb_dest = 0; wb_rf_en = 0;
  endtask

  // Expects to be called just after the rising edge where Reset was released.
  task automatic fill_check(input string tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk({tag, "_fill_le"}, {29'd0, pc_le[0], npc_le[0], if_id_le[0]}, 32'd0);
      chk({tag, "_fill_cmux"}, {31'd0, cmux[0]}, 32'd1);
      chk({tag, "_fill_state"}, {30'd0, st_o[0]}, 32'd0);
      chk({tag, "_fill_cnt"}, {16'd0, sc0}, k);
      sample_and_advance({tag, "_fill"});
    end
    @(negedge Clk);
    chk({tag, "_run_state"}, {30'd0, st_o[0]}, 32'd1);
    chk({tag, "_run_cnt"}, {16'd0, sc0}, 32'd3);
    chk({tag, "_run_le"}, {29'd0, pc_le[0], npc_le[0], if_id_le[0]}, 32'd7);
    sample_and_advance({tag, "_run"});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic hold;
    logic [4:0] rs, rt;
    logic urs, urt, br;
    logic [4:0] exd;
    logic exen, exld;
    logic [4:0] memd;
    logic memen;
    logic [4:0] wbd;
    logic wben;
    logic le;
    logic [1:0] fa, fb, st;
    logic [15:0] sc;
  } vec_t;

  function automatic vec_t mk(logic h, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic br, logic [4:0] exd, logic exen, logic exld,
                              logic [4:0] memd, logic memen, logic [4:0] wbd, logic wben,
                              logic le, logic [1:0] fa, logic [1:0] fb, logic [1:0] st,
                              logic [15:0] sc);
    vec_t v;
    v.hold = h; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br;
    v.exd = exd; v.exen = exen; v.exld = exld; v.memd = memd; v.memen = memen;
    v.wbd = wbd; v.wben = wben; v.le = le; v.fa = fa; v.fb = fb; v.st = st; v.sc = sc;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3);
    tbl[1]  = mk(0, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 3);  // load-use
    tbl[2]  = mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 2, 0, 1, 4);  // load now in MEM
    tbl[3]  = mk(0, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 4);  // branch on load
    tbl[4]  = mk(0, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2, 5);  // BR_STALL
    tbl[5]  = mk(0, 5, 0, 1, 0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 2, 0, 1, 6);
    tbl[6]  = mk(0, 0, 7, 0, 1, 0, 7, 1, 0, 7, 1, 7, 1, 1, 0, 1, 1, 6);
    tbl[7]  = mk(0, 0, 7, 0, 1, 0, 7, 0, 0, 7, 1, 7, 1, 1, 0, 2, 1, 6);
    tbl[8]  = mk(0, 0, 7, 0, 1, 0, 7, 0, 0, 7, 0, 7, 1, 1, 0, 3, 1, 6);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 7, 0, 7, 1, 1, 0, 0, 1, 6);  // r0 never forwarded
    tbl[10] = mk(0, 0, 7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 6);  // rt not read
    tbl[11] = mk(0, 3, 7, 1, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 6);  // rt load-use only
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7);
  end

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    Reset = 1'b0;
    model_reset();
    #1;
    step("rst");
    step("rst");
    Reset = 1'b1;
    fill_check("por");

    foreach (tbl[n]) begin
      hold = tbl[n].hold; id_rs = tbl[n].rs; id_rt = tbl[n].rt;
      id_uses_rs = tbl[n].urs; id_uses_rt = tbl[n].urt; id_branch = tbl[n].br;
      ex_dest = tbl[n].exd; ex_rf_en = tbl[n].exen; ex_load = tbl[n].exld;
      mem_dest = tbl[n].memd; mem_rf_en = tbl[n].memen;
      wb_dest = tbl[n].wbd; wb_rf_en = tbl[n].wben;
      @(negedge Clk);
      chk($sformatf("vec%0d_le", n), {29'd0, pc_le[0], npc_le[0], if_id_le[0]},
          tbl[n].le ? 32'd7 : 32'd0);
      chk($sformatf("vec%0d_cmux", n), {31'd0, cmux[0]}, {31'd0, ~tbl[n].le});
      chk($sformatf("vec%0d_fa", n), {30'd0, fa_o[0]}, {30'd0, tbl[n].fa});
      chk($sformatf("vec%0d_fb", n), {30'd0, fb_o[0]}, {30'd0, tbl[n].fb});
      chk($sformatf("vec%0d_st", n), {30'd0, st_o[0]}, {30'd0, tbl[n].st});
      chk($sformatf("vec%0d_sc", n), {16'd0, sc0}, {16'd0, tbl[n].sc});
      sample_and_advance("vec");
    end

    // hold for 4 cycles, then release with no extra bubble
    clear_inputs();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("hold_le", {29'd0, pc_le[0], npc_le[0], if_id_le[0]}, 32'd0);
      chk("hold_state", {30'd0, st_o[0]}, (k == 0) ? 32'd1 : 32'd3);
      sample_and_advance("hold");
    end
    hold = 1'b0;
    @(negedge Clk);
    chk("unhold_state", {30'd0, st_o[0]}, 32'd3);
    chk("unhold_le", {29'd0, pc_le[0], npc_le[0], if_id_le[0]}, 32'd7);
    chk("unhold_cnt", {16'd0, sc0}, 32'd11);
    sample_and_advance("unhold");
    @(negedge Clk);
    chk("after_hold_state", {30'd0, st_o[0]}, 32'd1);
    sample_and_advance("after_hold");

    // asynchronous reset in the middle of BR_STALL
    ex_load = 1; ex_dest = 5; ex_rf_en = 1; id_rs = 5; id_uses_rs = 1; id_branch = 1;
    step("brl");
    #2;
    chk("brst_state", {30'd0, st_o[0]}, 32'd2);
    Reset = 1'b0;
    model_reset();
    #1;
    chk("arst_le", {29'd0, pc_le[0], npc_le[0], if_id_le[0]}, 32'd0);
    chk("arst_cmux", {31'd0, cmux[0]}, 32'd1);
    chk("arst_fa", {30'd0, fa_o[0]}, 32'd0);
    chk("arst_state", {30'd0, st_o[0]}, 32'd0);
    chk("arst_cnt", {16'd0, sc0}, 32'd0);
    step("arst");
    Reset = 1'b1;
    clear_inputs();
    fill_check("rerun");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Reset      = ($urandom_range(0, 199) != 0);
      if (!Reset) model_reset();
      hold       = ($urandom_range(0, 9) == 0);
      id_rs      = 5'($urandom_range(0, 7));
      id_rt      = 5'($urandom_range(0, 7));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      id_branch  = 1'($urandom);
      ex_dest    = 5'($urandom_range(0, 7));
      ex_rf_en   = 1'($urandom);
      ex_load    = 1'($urandom);
      mem_dest   = 5'($urandom_range(0, 7));
      mem_rf_en  = 1'($urandom);
      wb_dest    = 5'($urandom_range(0, 7));
      wb_rf_en   = 1'($urandom);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequencing controller for the 5-stage MIPS pipeline.
- Drives the front-end load enables for PC, nPC and IF/ID, and the ControlUnitMUX select (CMUX) that replaces ID control signals with a NOP bubble.
- Generates forwarding selects for the two ID-stage operands.
- Detects load-use and branch-on-load hazards, inserts the required bubbles, and runs a post-reset pipeline-fill sequence.

Parameters:
- FILL_CYCLES, 3, bubbles injected after reset before normal fetch (1..7).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous reset, active-low (0 = reset).
- hold  in  1  external freeze request (debug/single-step).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_branch  in  1  ID instruction resolves in ID using rs (BGTZ, JR).
- ex_dest  in  5  destination register in EX.
- ex_rf_en  in  1  RegFileEnable in EX.
- ex_load  in  1  EX instruction is a load.
- mem_dest  in  5  destination register in MEM.
- mem_rf_en  in  1  RegFileEnable in MEM.
- wb_dest  in  5  destination register in WB.
- wb_rf_en  in  1  RegFileEnable in WB.
- pc_le  out  1  PC register load enable.
- npc_le  out  1  nPC register load enable.
- if_id_le  out  1  IF/ID register load enable.
- cmux  out  1  1 = ControlUnitMUX outputs all-zero (NOP) control.
- fwd_a  out  2  rs operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
- fwd_b  out  2  rt operand select, same encoding.
- stall_cnt  out  CNT_W  count of bubble cycles since reset; saturates at all-ones.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- FSM states: FILL=00, RUN=01, BR_STALL=10, FREEZE=11. State and fill counter are registered. All other outputs are combinational from state and inputs, except stall_cnt, which is registered.
- Reset (Reset=0, asynchronous): state=FILL, fill counter=0, stall_cnt=0. While in reset: pc_le=npc_le=if_id_le=0, cmux=1, fwd_a=fwd_b=00.
- FILL:
  - Outputs: pc_le=npc_le=if_id_le=0, cmux=1.
  - Fill counter increments each cycle.
  - When the counter reaches FILL_CYCLES-1, next state is RUN. Exactly FILL_CYCLES bubble cycles are produced.
  - hold is ignored in FILL.
- Hazard terms:
  - match_rs(x) = (x==id_rs) & id_uses_rs & (x!=0); match_rt(x) is defined the same way on rt.
  - lu = ex_load & ex_rf_en & (match_rs(ex_dest) | match_rt(ex_dest)).
  - brl = lu & id_branch & match_rs(ex_dest).
- RUN, priority order:
  - If hold: outputs as bubble (all LE=0, cmux=1); next state FREEZE.
  - Else if brl: bubble; next state BR_STALL. This gives 2 bubbles total, because load data is needed in ID before the end of MEM.
  - Else if lu: bubble for this cycle only; next state RUN. On the next cycle the load is in MEM and is forwarded.
  - Else: all LE=1, cmux=0.
- BR_STALL: unconditional bubble; next state RUN. hold sampled here takes effect from the next RUN cycle.
- FREEZE: bubble while hold=1; on hold=0, next state RUN with no extra bubble.
- Bubble definition: pc_le=npc_le=if_id_le=0 and cmux=1, in the same cycle.
- stall_cnt increments on every bubble cycle in FILL, RUN, BR_STALL and FREEZE. It holds at 2^CNT_W-1.
- Forwarding:
  - Priority EX > MEM > WB, each qualified by its rf_en and match.
  - Register 0 is never forwarded, so the select is 00.
  - fwd outputs are valid in all states; they do not depend on the stall decision.
  - An EX match with ex_load=1 still yields 01; lu ensures the value is not consumed.
- Reset asserted mid-stall: immediate return to FILL; stall_cnt is cleared.

Decomposition:
- Shared package (hazard_pkg):
  - state encodings FILL/RUN/BR_STALL/FREEZE;
  - forwarding encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB;
  - REG_ZERO = 5'd0.
- One sub-module, fwd_select: a combinational priority mux, instantiated twice (rs, rt).

Test Plan:
- Reset low 2 cycles, then high → cmux=1 and LEs=0 for exactly 3 cycles, state 00→01, stall_cnt=3.
- RUN, ex_load=1, ex_dest=5, ex_rf_en=1, id_rs=5, id_uses_rs=1, id_branch=0 → one bubble cycle, then LEs=1; stall_cnt +1.
- Same as above with id_branch=1 → bubble for 2 consecutive cycles (state 01→10→01); stall_cnt +2.
- ex_dest=mem_dest=wb_dest=7, all rf_en=1, id_rt=7, id_uses_rt=1, ex_load=0 → fwd_b=01. Then ex_rf_en=0 → 10. Then mem_rf_en=0 → 11. Then id_rt=0 → 00.
- hold=1 for 4 cycles in RUN → state 11, 4 bubbles; hold=0 → LEs=1 on the next cycle.
- Reset pulsed low during BR_STALL → outputs are bubble immediately (asynchronous), stall_cnt=0, FILL sequence restarts.
